uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an integrated transmit FIFO, configurable frame format (5–9 data bits, none/odd/even parity, 1 or 2 stop bits) and a valid/ready input handshake. It sits between on-chip producers and the board UART TX pin. Buffered bytes go out as back-to-back frames with no idle gap, so the producer need not track per-frame busy status.

---
 rtl/uart_tx_fifo.sv | 203 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO and configurable frame format.
// Queued words go out as back-to-back frames with no idle gap between them.
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [PAYLOAD_BITS-1:0]       s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          uart_txd,
    output logic                          uart_tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    // state   | meaning
    // S_IDLE  | line high, waiting for the FIFO to hold a word
    // S_START | start bit (line low)
    // S_DATA  | payload bits, LSB first
    // S_PAR   | parity bit (only when PARITY != 0)
    // S_STOP  | stop bit(s), line high

    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int BW  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic                    push;
    logic                    pop;
    logic                    fifo_empty;
    logic [PAYLOAD_BITS-1:0] head;

    state_t                  state_q, state_n;
    logic [CW-1:0]           cyc_q, cyc_n;
    logic [BW-1:0]           bit_q, bit_n;
    logic [PAYLOAD_BITS-1:0] sh_q, sh_n;
    logic                    par_q, par_n;
    logic                    txd_n;
    logic                    done_n;
    logic                    bit_end;

    assign s_ready      = (fifo_level != LW'(FIFO_DEPTH));
    assign push         = s_valid && s_ready;
    assign fifo_empty   = (fifo_level == '0);
    assign head         = mem[rd_ptr];
    assign uart_tx_busy = (state_q != S_IDLE) || !fifo_empty;
    assign bit_end      = (cyc_q == CW'(CPB - 1));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // Readiness depends only on occupancy, so a pop never frees a slot for a same-cycle push.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_comb begin
        state_n = state_q;
        cyc_n   = cyc_q;
        bit_n   = bit_q;
        sh_n    = sh_q;
        par_n   = par_q;
        pop     = 1'b0;
        done_n  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    sh_n    = head;
                    par_n   = (PARITY == 1) ? ~^head : ^head;
                    cyc_n   = '0;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cyc_n   = '0;
                    bit_n   = '0;
                    state_n = S_DATA;
                end else begin
                    cyc_n = cyc_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cyc_n = '0;
                    sh_n  = sh_q >> 1;
                    if (bit_q == BW'(PAYLOAD_BITS - 1)) begin
                        bit_n   = '0;
                        state_n = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_n = bit_q + 1'b1;
                    end
                end else begin
                    cyc_n = cyc_q + 1'b1;
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    cyc_n   = '0;
                    bit_n   = '0;
                    state_n = S_STOP;
                end else begin
                    cyc_n = cyc_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cyc_n = '0;
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        bit_n  = '0;
                        done_n = 1'b1;
                        // Chain straight into the next start bit when more words are queued.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            sh_n    = head;
                            par_n   = (PARITY == 1) ? ~^head : ^head;
                            state_n = S_START;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        bit_n = bit_q + 1'b1;
                    end
                end else begin
                    cyc_n = cyc_q + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cyc_n   = '0;
                bit_n   = '0;
            end
        endcase

        case (state_n)
            S_START: txd_n = 1'b0;
            S_DATA:  txd_n = sh_n[0];
            S_PAR:   txd_n = par_n;
            default: txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            par_q    <= 1'b0;
            uart_txd <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            state_q  <= state_n;
            cyc_q    <= cyc_n;
            bit_q    <= bit_n;
            sh_q     <= sh_n;
            par_q    <= par_n;
            uart_txd <= txd_n;
            tx_done  <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four frame formats at 10 cycles/bit, expected
// bytes queued on acceptance and checked bit-by-bit as the line serialises them.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] s_valid;
    logic [3:0] s_ready;
    logic [3:0] txd;
    logic [3:0] busy;
    logic [3:0] done;
    logic [7:0] d_n1, d_e2, d_o1;
    logic [4:0] d_p5;
    logic [2:0] lvl [4];

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] sb [$];
    int fill_lvl [6] = '{1, 1, 2, 3, 4, 4};

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_HZ(100_000_000), .BIT_RATE(10_000_000), .PAYLOAD_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_n1 (
        .clk(clk), .resetn(resetn), .s_data(d_n1), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .uart_txd(txd[0]), .uart_tx_busy(busy[0]), .tx_done(done[0]), .fifo_level(lvl[0]));

    uart_tx_fifo #(.CLK_HZ(100_000_000), .BIT_RATE(10_000_000), .PAYLOAD_BITS(8),
                   .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_e2 (
        .clk(clk), .resetn(resetn), .s_data(d_e2), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .uart_txd(txd[1]), .uart_tx_busy(busy[1]), .tx_done(done[1]), .fifo_level(lvl[1]));

    uart_tx_fifo #(.CLK_HZ(100_000_000), .BIT_RATE(10_000_000), .PAYLOAD_BITS(8),
                   .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_o1 (
        .clk(clk), .resetn(resetn), .s_data(d_o1), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
        .uart_txd(txd[2]), .uart_tx_busy(busy[2]), .tx_done(done[2]), .fifo_level(lvl[2]));

    uart_tx_fifo #(.CLK_HZ(100_000_000), .BIT_RATE(10_000_000), .PAYLOAD_BITS(5),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_p5 (
        .clk(clk), .resetn(resetn), .s_data(d_p5), .s_valid(s_valid[3]), .s_ready(s_ready[3]),
        .uart_txd(txd[3]), .uart_tx_busy(busy[3]), .tx_done(done[3]), .fifo_level(lvl[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level for frame bit b (0 = start bit).
    function automatic logic exp_bit(input logic [7:0] v, input int nbits, input int par, input int b);
        int ones;
        ones = 0;
        for (int i = 0; i < nbits; i++) ones += int'(v[i]);
        if (b == 0) return 1'b0;
        if (b <= nbits) return v[b-1];
        if (par != 0 && b == nbits + 1) return (par == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        return 1'b1;
    endfunction

    // Called at a negedge; drives one word for exactly one rising edge.
    task automatic push_one(input int inst, input logic [7:0] val);
        case (inst)
            0:       d_n1 = val;
            1:       d_e2 = val;
            2:       d_o1 = val;
            default: d_p5 = val[4:0];
        endcase
        s_valid[inst] = 1'b1;
        chk("push_ready", s_ready[inst], 1'b1);
        @(negedge clk);
        s_valid[inst] = 1'b0;
        sb.push_back(val);
    endtask

    // n0 is the number of edges since the start-bit edge at the moment of the call.
    task automatic run_frame(input int inst, input int nbits, input int par, input int nstop,
                             input int n0, output int len, output int hi_run);
        logic [7:0] v;
        int  nb;
        bit  seen;
        nb = 1 + nbits + ((par != 0) ? 1 : 0) + nstop;
        v  = 8'h00;
        if (sb.size() == 0) chk("sb_nonempty", 0, 1);
        else v = sb.pop_front();
        seen   = 1'b0;
        len    = 0;
        hi_run = 0;
        for (int n = n0 + 1; n <= n0 + 400 && !seen; n++) begin
            @(negedge clk);
            if (done[inst] === 1'b1) begin
                seen = 1'b1;
                len  = n;
            end else begin
                if (txd[inst] === 1'b1) hi_run++;
                else hi_run = 0;
                if ((n % 10) == 5 && (n / 10) < nb)
                    chk($sformatf("line_bit%0d", n / 10), txd[inst], exp_bit(v, nbits, par, n / 10));
            end
        end
        chk("frame_end_seen", seen, 1);
    endtask

    task automatic single_frame(input int inst, input logic [7:0] val, input int nbits,
                                input int par, input int nstop, input int exp_len, output int hr);
        int len;
        push_one(inst, val);
        chk("lvl_after_push", lvl[inst], 1);
        chk("txd_idle_at_accept", txd[inst], 1);
        @(negedge clk);
        chk("txd_start_edge", txd[inst], 0);
        chk("lvl_after_pop", lvl[inst], 0);
        chk("busy_in_frame", busy[inst], 1);
        run_frame(inst, nbits, par, nstop, 0, len, hr);
        chk("frame_len", len, exp_len);
        chk("busy_at_done", busy[inst], 0);
        chk("txd_idle_after", txd[inst], 1);
        @(negedge clk);
        chk("done_single_cycle", done[inst], 0);
    endtask

    initial begin
        int hr;
        int len;
        int cnt;
        resetn  = 1'b0;
        s_valid = '0;
        d_n1    = '0;
        d_e2    = '0;
        d_o1    = '0;
        d_p5    = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rst_txd", txd[i], 1);
            chk("rst_ready", s_ready[i], 1);
            chk("rst_busy", busy[i], 0);
            chk("rst_done", done[i], 0);
            chk("rst_level", lvl[i], 0);
        end
        resetn = 1'b1;
        @(negedge clk);

        single_frame(0, 8'hA5, 8, 0, 1, 100, hr);
        single_frame(1, 8'hA5, 8, 2, 2, 120, hr);
        chk("stop_high_2stop", hr, 20);
        single_frame(2, 8'hA5, 8, 1, 1, 110, hr);
        single_frame(3, 8'h13, 5, 0, 1, 70, hr);

        // Hold valid high with 0x01..0x06 into the 4-deep FIFO.
        d_n1       = 8'h01;
        s_valid[0] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i <= 5) sb.push_back(8'(i));
            chk("fill_level", lvl[0], fill_lvl[i-1]);
            chk("fill_ready", s_ready[0], (i >= 5) ? 0 : 1);
            d_n1 = 8'(i + 1);
        end
        s_valid[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            run_frame(0, 8, 0, 1, (k == 0) ? 4 : 0, len, hr);
            chk("b2b_len", len, 100);
            chk("b2b_gap_txd", txd[0], (k < 4) ? 0 : 1);
        end
        chk("b2b_busy_end", busy[0], 0);
        chk("b2b_level_end", lvl[0], 0);

        // Abort a frame mid-DATA with more words queued.
        @(negedge clk);
        d_n1       = 8'h11;
        s_valid[0] = 1'b1;
        @(negedge clk);
        d_n1 = 8'h22;
        @(negedge clk);
        d_n1 = 8'h33;
        @(negedge clk);
        s_valid[0] = 1'b0;
        chk("abort_level_queued", lvl[0], 2);
        repeat (34) @(negedge clk);
        chk("abort_txd_mid_data", txd[0], 0);
        #2 resetn = 1'b0;
        #1;
        chk("abort_txd_async", txd[0], 1);
        chk("abort_level_async", lvl[0], 0);
        chk("abort_ready_async", s_ready[0], 1);
        chk("abort_busy_async", busy[0], 0);
        repeat (2) @(negedge clk);
        chk("abort_txd_held", txd[0], 1);
        chk("abort_level_held", lvl[0], 0);
        resetn = 1'b1;
        sb.delete();
        cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (txd[0] !== 1'b1 || done[0] !== 1'b0 || busy[0] !== 1'b0) cnt++;
        end
        chk("no_frame_after_reset", cnt, 0);
        single_frame(0, 8'h3C, 8, 0, 1, 100, hr);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
